reservation_station: RTL

Out-of-order issue buffer that sits directly upstream of the ALU. It accepts decoded integer, branch and jump instructions from dispatch and holds each one until both source operands are available. Missing operands are captured from the ALU and load/store result broadcast buses. Each cycle it issues at most one ready instruction to the ALU through a registered issue port. The whole buffer is discarded on a misprediction clear.

---
 rtl/reservation_station.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/reservation_station.sv
// Out-of-order issue buffer in front of the ALU: holds dispatched ops until both
// operands arrive (directly, by bypass, or by result broadcast), issues one per cycle.
module reservation_station #(
  parameter int unsigned RS_SIZE = 16,
  parameter int unsigned ROB_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clr_in,
  input  logic             dec_valid,
  input  logic [5:0]       dec_op,
  input  logic [3:0]       dec_opType,
  input  logic [31:0]      dec_rs1_val,
  input  logic [31:0]      dec_rs2_val,
  input  logic             dec_rs1_busy,
  input  logic             dec_rs2_busy,
  input  logic [ROB_W-1:0] dec_rs1_tag,
  input  logic [ROB_W-1:0] dec_rs2_tag,
  input  logic [ROB_W-1:0] dec_rob_index,
  input  logic [31:0]      dec_PC,
  input  logic [31:0]      dec_imm,
  output logic             rs_full,
  input  logic             alu_ready,
  input  logic [ROB_W-1:0] alu_rob_index,
  input  logic [31:0]      alu_result,
  input  logic             lsb_ready,
  input  logic [ROB_W-1:0] lsb_rob_index,
  input  logic [31:0]      lsb_result,
  output logic             rs_to_alu_ready,
  output logic [5:0]       rs_to_alu_op,
  output logic [3:0]       rs_to_alu_opType,
  output logic [31:0]      rs_to_alu_rs1,
  output logic [31:0]      rs_to_alu_rs2,
  output logic [ROB_W-1:0] rs_to_alu_rob_index,
  output logic [31:0]      rs_to_alu_PC,
  output logic [31:0]      rs_to_alu_imm
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned TYPE_W = 4;
  localparam int unsigned IDX_W  = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TYPE_W-1:0] op_type;
    logic [XLEN-1:0]   vj;
    logic [XLEN-1:0]   vk;
    logic              qj_busy;
    logic              qk_busy;
    logic [ROB_W-1:0]  qj;
    logic [ROB_W-1:0]  qk;
    logic [ROB_W-1:0]  rob_index;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
  } rs_entry_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TYPE_W-1:0] op_type;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [ROB_W-1:0]  rob_index;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
  } issue_t;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  rs_entry_t          ent_q [RS_SIZE];
  rs_entry_t          ent_d [RS_SIZE];
  logic               issue_vld_q, issue_vld_d;
  issue_t             issue_q, issue_d;

  logic               free_found, rdy_found;
  logic [IDX_W-1:0]   free_idx, rdy_idx;
  rs_entry_t          new_ent;
  logic [XLEN:0]      byp_j, byp_k, wake_j, wake_k;

  // Result-bus lookup: {hit, value}, ALU bus wins when both buses carry the tag.
  function automatic logic [XLEN:0] snoop(
    input logic [ROB_W-1:0] tag,
    input logic             a_vld,
    input logic [ROB_W-1:0] a_tag,
    input logic [XLEN-1:0]  a_val,
    input logic             l_vld,
    input logic [ROB_W-1:0] l_tag,
    input logic [XLEN-1:0]  l_val
  );
    logic [XLEN:0] res;
    res = '0;
    if (a_vld && (a_tag == tag))      res = {1'b1, a_val};
    else if (l_vld && (l_tag == tag)) res = {1'b1, l_val};
    return res;
  endfunction

  assign rs_full = &busy_q;

  // Lowest-index free slot and lowest-index issuable slot, from registered state.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!free_found && !busy_q[IDX_W'(i)]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!rdy_found && busy_q[IDX_W'(i)] &&
          !ent_q[IDX_W'(i)].qj_busy && !ent_q[IDX_W'(i)].qk_busy) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
    end
  end

  // Incoming entry with same-cycle broadcast bypass applied to busy operands.
  always_comb begin
    new_ent           = '0;
    new_ent.op        = dec_op;
    new_ent.op_type   = dec_opType;
    new_ent.vj        = dec_rs1_val;
    new_ent.vk        = dec_rs2_val;
    new_ent.qj_busy   = dec_rs1_busy;
    new_ent.qk_busy   = dec_rs2_busy;
    new_ent.qj        = dec_rs1_tag;
    new_ent.qk        = dec_rs2_tag;
    new_ent.rob_index = dec_rob_index;
    new_ent.pc        = dec_PC;
    new_ent.imm       = dec_imm;
    byp_j = snoop(dec_rs1_tag, alu_ready, alu_rob_index, alu_result,
                  lsb_ready, lsb_rob_index, lsb_result);
    byp_k = snoop(dec_rs2_tag, alu_ready, alu_rob_index, alu_result,
                  lsb_ready, lsb_rob_index, lsb_result);
    if (dec_rs1_busy && byp_j[XLEN]) begin
      new_ent.vj      = byp_j[XLEN-1:0];
      new_ent.qj_busy = 1'b0;
    end
    if (dec_rs2_busy && byp_k[XLEN]) begin
      new_ent.vk      = byp_k[XLEN-1:0];
      new_ent.qk_busy = 1'b0;
    end
  end

  // Next state: wakeup, issue, dispatch.
  always_comb begin
    busy_d      = busy_q;
    ent_d       = ent_q;
    issue_vld_d = 1'b0;
    issue_d     = issue_q;
    wake_j      = '0;
    wake_k      = '0;

    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      wake_j = snoop(ent_q[IDX_W'(i)].qj, alu_ready, alu_rob_index, alu_result,
                     lsb_ready, lsb_rob_index, lsb_result);
      wake_k = snoop(ent_q[IDX_W'(i)].qk, alu_ready, alu_rob_index, alu_result,
                     lsb_ready, lsb_rob_index, lsb_result);
      if (busy_q[IDX_W'(i)] && ent_q[IDX_W'(i)].qj_busy && wake_j[XLEN]) begin
        ent_d[IDX_W'(i)].vj      = wake_j[XLEN-1:0];
        ent_d[IDX_W'(i)].qj_busy = 1'b0;
      end
      if (busy_q[IDX_W'(i)] && ent_q[IDX_W'(i)].qk_busy && wake_k[XLEN]) begin
        ent_d[IDX_W'(i)].vk      = wake_k[XLEN-1:0];
        ent_d[IDX_W'(i)].qk_busy = 1'b0;
      end
    end

    if (rdy_found) begin
      busy_d[rdy_idx]   = 1'b0;
      issue_vld_d       = 1'b1;
      issue_d.op        = ent_q[rdy_idx].op;
      issue_d.op_type   = ent_q[rdy_idx].op_type;
      issue_d.rs1       = ent_q[rdy_idx].vj;
      issue_d.rs2       = ent_q[rdy_idx].vk;
      issue_d.rob_index = ent_q[rdy_idx].rob_index;
      issue_d.pc        = ent_q[rdy_idx].pc;
      issue_d.imm       = ent_q[rdy_idx].imm;
    end

    // The issuing slot is still busy here, so a freed slot is reused next cycle.
    if (dec_valid && free_found) begin
      busy_d[free_idx] = 1'b1;
      ent_d[free_idx]  = new_ent;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      issue_vld_q <= 1'b0;
      issue_q     <= '0;
    end else if (clr_in) begin
      busy_q      <= '0;
      issue_vld_q <= 1'b0;
    end else if (rdy_in) begin
      busy_q      <= busy_d;
      ent_q       <= ent_d;
      issue_vld_q <= issue_vld_d;
      issue_q     <= issue_d;
    end
  end

  assign rs_to_alu_ready     = issue_vld_q;
  assign rs_to_alu_op        = issue_q.op;
  assign rs_to_alu_opType    = issue_q.op_type;
  assign rs_to_alu_rs1       = issue_q.rs1;
  assign rs_to_alu_rs2       = issue_q.rs2;
  assign rs_to_alu_rob_index = issue_q.rob_index;
  assign rs_to_alu_PC        = issue_q.pc;
  assign rs_to_alu_imm       = issue_q.imm;

endmodule
